uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (8N1, 16x oversampled tick) between NREQ byte sources, e.g. the LED, 7-segment and LCD status channels.
- Grants requesters round-robin and captures the winner's byte.
- Sequences the transmitter's t_en/din/tx_busy handshake until the frame completes, then re-arbitrates.
- Sits between the requester logic and the transmitter, in the clk_50Mhz domain.

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Function : round-robin sharing of one 8N1 UART transmitter among NREQ byte
//            sources; optional start timeout via UART_TX_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DBITS   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk_50Mhz,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DBITS-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      tx_busy,
    output logic                      t_en,
    output logic [DBITS-1:0]          din,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      active,
    output logic                      done,
    output logic                      err
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;

    logic [DBITS-1:0] w_bytes [NREQ];
    logic [IDW-1:0]   w_scan;
    logic [IDW-1:0]   w_winner;
    logic             w_found;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_bytes[gi] = req_data[gi*DBITS +: DBITS];
        end
    endgenerate

    // Walk from the slot after the last winner, wrapping at NREQ-1, and keep
    // the first valid requester seen.
    always_comb begin
        w_scan   = r_rr_ptr;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = (w_scan == IDW'(NREQ-1)) ? '0 : w_scan + 1'b1;
            if (!w_found && req_valid[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0] r_tmo_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= IDW'(NREQ-1);
            req_ready <= '0;
            t_en      <= 1'b0;
            din       <= '0;
            grant_id  <= '0;
            active    <= 1'b0;
            done      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            err       <= 1'b0;
            r_tmo_cnt <= '0;
`endif
        end else begin
            req_ready <= '0;
            t_en      <= 1'b0;
            done      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            err       <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // A transmitter left busy by an earlier operation blocks any grant.
                    if (!tx_busy && w_found) begin
                        din       <= w_bytes[w_winner];
                        grant_id  <= w_winner;
                        r_rr_ptr  <= w_winner;
                        req_ready <= NREQ'(1) << w_winner;
                        t_en      <= 1'b1;
                        active    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                S_WAIT_BUSY: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_tmo_cnt == TW'(TIMEOUT-1)) begin
                        // Byte is dropped; rr_ptr already points at this winner.
                        err     <= 1'b1;
                        active  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`else
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
`endif
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        done    <= 1'b1;
                        active  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    active  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Function : directed + randomized self-checking bench for uart_tx_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DBITS   = 8;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ*DBITS-1:0]   req_data  = '0;
    logic                    tx_busy   = 1'b0;
    logic [NREQ-1:0]         req_ready;
    logic                    t_en;
    logic [DBITS-1:0]        din;
    logic [IDW-1:0]          grant_id;
    logic                    active;
    logic                    done;
    logic                    err;

    int n_pass  = 0;
    int n_total = 0;
    int m_ptr   = NREQ-1;   // model: index of the last requester granted

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .TIMEOUT(TIMEOUT)) dut (
        .clk_50Mhz (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_busy   (tx_busy),
        .t_en      (t_en),
        .din       (din),
        .grant_id  (grant_id),
        .active    (active),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Round-robin reference: first valid requester after the last winner.
    function automatic int pick(input logic [NREQ-1:0] m);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (m[idx[IDW-1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  req_ready, 0);
        check({tag, "_t_en"},   t_en,      0);
        check({tag, "_din"},    din,       0);
        check({tag, "_id"},     grant_id,  0);
        check({tag, "_active"}, active,    0);
        check({tag, "_done"},   done,      0);
        check({tag, "_err"},    err,       0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("rst");
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = NREQ-1;
    endtask

    // One complete frame. Optionally holds tx_busy high first, then plays the
    // transmitter: busy rises rise_dly cycles after t_en and lasts busy_len.
    task automatic serve(input logic [NREQ-1:0] mask, input logic [NREQ*DBITS-1:0] data,
                         input int hold_busy, input int rise_dly, input int busy_len,
                         input bit churn);
        int w;
        logic [DBITS-1:0] b;
        req_valid = mask;
        req_data  = data;
        if (hold_busy > 0) begin
            tx_busy = 1'b1;
            repeat (hold_busy) begin
                @(negedge clk);
                check("hold_t_en",   t_en,      0);
                check("hold_ready",  req_ready, 0);
                check("hold_active", active,    0);
            end
            tx_busy = 1'b0;
        end
        w = pick(mask);
        b = data[w*DBITS +: DBITS];
        @(negedge clk);
        check("grant_ready",  req_ready, 1 << w);
        check("grant_t_en",   t_en,      1);
        check("grant_din",    din,       b);
        check("grant_id",     grant_id,  w);
        check("grant_active", active,    1);
        check("grant_done",   done,      0);
        m_ptr    = w;
        req_data = {$urandom};
        if (churn) req_valid = NREQ'($urandom);
        @(negedge clk);
        check("issue_t_en",  t_en,      0);
        check("issue_ready", req_ready, 0);
        check("issue_din",   din,       b);
        repeat (rise_dly) begin
            @(negedge clk);
            check("wb_active", active,    1);
            check("wb_ready",  req_ready, 0);
            if (churn) req_valid = NREQ'($urandom);
        end
        tx_busy = 1'b1;
        repeat (busy_len) begin
            @(negedge clk);
            check("wd_done",  done,      0);
            check("wd_t_en",  t_en,      0);
            check("wd_ready", req_ready, 0);
            if (churn) req_valid = NREQ'($urandom);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        check("done_pulse",  done,   1);
        check("done_active", active, 0);
        check("done_din",    din,    b);
        check("done_err",    err,    0);
        req_valid = '0;
    endtask

    initial begin
        do_reset();

        // single request from requester 2
        serve(4'b0100, 32'h005A_0000, 0, 1, 8, 1'b0);

        // all valid continuously: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NREQ+1; i++) begin
            serve(4'b1111, 32'h1312_1110, 0, i % 3, 3, 1'b0);
            check("rr_order", grant_id, i % NREQ);
        end

        // sparse: after 3, requesters 1 and 3 -> 1 then 3
        serve(4'b1000, 32'hA3A2_A1A0, 0, 0, 2, 1'b0);
        serve(4'b1010, 32'hB3B2_B1B0, 0, 1, 2, 1'b0);
        check("sparse_first", grant_id, 1);
        serve(4'b1010, 32'hC3C2_C1C0, 0, 0, 2, 1'b0);
        check("sparse_second", grant_id, 3);

        // busy hold-off
        serve(4'b0001, 32'h0000_00E7, 4, 0, 3, 1'b0);

        // randomized traffic against the round-robin model
        for (int i = 0; i < 40; i++) begin
            serve(NREQ'($urandom_range(1, (1 << NREQ) - 1)), {$urandom},
                  $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(1, 6), 1'b1);
        end

        // reset during WAIT_DONE, transmitter still busy afterwards
        do_reset();
        req_valid = 4'b0100;
        req_data  = 32'h0077_0000;
        @(negedge clk);
        tx_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_active", active, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        req_valid = 4'b1111;
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = NREQ-1;
        serve(4'b1111, 32'h4433_2211, 3, 0, 2, 1'b0);
        check("post_rst_id", grant_id, 0);

        // start timeout behaviour
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000_5500;
        @(negedge clk);
        check("to_grant_id", grant_id, 1);
        m_ptr = 1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        repeat (TIMEOUT) begin
            @(negedge clk);
            check("to_err_low", err,    0);
            check("to_active",  active, 1);
        end
        @(negedge clk);
        check("to_err_pulse", err,    1);
        check("to_idle",      active, 0);
        check("to_no_done",   done,   0);
        req_valid = '0;
        @(negedge clk);
        check("to_err_once", err, 0);
        serve(4'b0110, 32'h0066_5500, 0, 0, 2, 1'b0);
        check("to_next_id", grant_id, 2);
`else
        repeat (TIMEOUT + 8) begin
            @(negedge clk);
            check("nto_err",    err,    0);
            check("nto_active", active, 1);
            check("nto_done",   done,   0);
        end
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
